// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: sticky pending bits, per-channel mask, global enable,
// highest-index arbitration and a REQ/SERV handshake with the core.
module irq_ctrl #(
    parameter int unsigned N_IRQ = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [N_IRQ-1:0] irq_in_i,
    input  logic             mask_wr_i,
    input  logic [N_IRQ-1:0] mask_wdata_i,
    input  logic             ien_wr_i,
    input  logic             ien_wdata_i,
    input  logic             irq_ack_i,
    input  logic             eoi_i,
    input  logic             cnt_clr_i,
    output logic             irq_valid_o,
    output logic [$clog2(N_IRQ)-1:0] irq_id_o,
    output logic             in_service_o,
    output logic [N_IRQ-1:0] pending_o,
    output logic [CNT_W-1:0] lost_cnt_o,
    output logic [7:0]       status_o
);
    localparam int unsigned ID_W = $clog2(N_IRQ);

    typedef enum logic [1:0] {StIdle, StReq, StServ} state_e;

    state_e           state_q;
    logic [N_IRQ-1:0] irq_q, irq_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic             int_en_q, int_en_d;
    logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;
    logic [ID_W-1:0]  irq_id_q;
    logic             irq_valid_q;
    logic             in_service_q;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] elig;
    logic             lost;
    logic             ack_take;
    logic [ID_W-1:0]  win_id;

    assign rise     = irq_in_i & ~irq_q;
    assign ack_take = (state_q == StReq) && irq_ack_i;
    assign clr      = ack_take ? ({{(N_IRQ-1){1'b0}}, 1'b1} << irq_id_q) : '0;
    // A rise on a channel that is being acked this cycle is a fresh request, not a drop.
    assign lost     = |(rise & pending_q & ~clr);
    assign elig     = pending_q & ~mask_q;

    always_comb begin
        win_id = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (elig[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        irq_d     = irq_in_i;
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_wr_i ? mask_wdata_i : mask_q;
        int_en_d  = ien_wr_i ? ien_wdata_i : int_en_q;
        lost_cnt_d = lost_cnt_q;
        if (cnt_clr_i) begin
            lost_cnt_d = '0;
        end else if (lost && (lost_cnt_q != {CNT_W{1'b1}})) begin
            lost_cnt_d = lost_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            irq_q      <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            int_en_q   <= 1'b0;
            lost_cnt_q <= '0;
        end else begin
            irq_q      <= irq_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            int_en_q   <= int_en_d;
            lost_cnt_q <= lost_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q      <= StIdle;
            irq_id_q     <= '0;
            irq_valid_q  <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (int_en_q && (|elig)) begin
                        irq_id_q    <= win_id;
                        irq_valid_q <= 1'b1;
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    // Mask or enable changes never retract a vector already presented.
                    if (irq_ack_i) begin
                        irq_valid_q  <= 1'b0;
                        in_service_q <= 1'b1;
                        state_q      <= StServ;
                    end
                end
                StServ: begin
                    if (eoi_i) begin
                        in_service_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    irq_valid_q  <= 1'b0;
                    in_service_q <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    assign irq_valid_o  = irq_valid_q;
    assign irq_id_o     = irq_id_q;
    assign in_service_o = in_service_q;
    assign pending_o    = pending_q;
    assign lost_cnt_o   = lost_cnt_q;
    assign status_o     = {int_en_q, irq_valid_q, in_service_q, |elig, 4'b0000};

endmodule

// File: tb/tb_irq_ctrl.sv
// Table-driven bench for irq_ctrl (N_IRQ=8, CNT_W=8) plus a lost-counter saturation sequence.
module tb_irq_ctrl;
    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] irq_in;
    logic       mask_wr;
    logic [7:0] mask_wdata;
    logic       ien_wr;
    logic       ien_wdata;
    logic       irq_ack;
    logic       eoi;
    logic       cnt_clr;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       in_service;
    logic [7:0] pending;
    logic [7:0] lost_cnt;
    logic [7:0] status;

    int checks = 0;
    int failures = 0;

    irq_ctrl #(.N_IRQ(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .irq_in_i    (irq_in),
        .mask_wr_i   (mask_wr),
        .mask_wdata_i(mask_wdata),
        .ien_wr_i    (ien_wr),
        .ien_wdata_i (ien_wdata),
        .irq_ack_i   (irq_ack),
        .eoi_i       (eoi),
        .cnt_clr_i   (cnt_clr),
        .irq_valid_o (irq_valid),
        .irq_id_o    (irq_id),
        .in_service_o(in_service),
        .pending_o   (pending),
        .lost_cnt_o  (lost_cnt),
        .status_o    (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] irq;
        logic       mwr;
        logic [7:0] mdat;
        logic       iwr;
        logic       idat;
        logic       ack;
        logic       eoi;
        logic       cclr;
        logic       vld;
        logic [2:0] id;
        logic       srv;
        logic [7:0] pend;
        logic [7:0] lost;
        logic [7:0] stat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [7:0] i, logic mw, logic [7:0] md, logic iw,
                                logic id_, logic a, logic e, logic c, logic v, logic [2:0] x,
                                logic s, logic [7:0] p, logic [7:0] l, logic [7:0] st);
        vec_t t;
        t.rst_n = r; t.irq = i; t.mwr = mw; t.mdat = md; t.iwr = iw; t.idat = id_;
        t.ack = a; t.eoi = e; t.cclr = c;
        t.vld = v; t.id = x; t.srv = s; t.pend = p; t.lost = l; t.stat = st;
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rstN = 1'b1; irq_in = '0; mask_wr = 1'b0; mask_wdata = '0; ien_wr = 1'b0;
        ien_wdata = 1'b0; irq_ack = 1'b0; eoi = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        //            rst irq   mw md    iw id a  e  c    vld id   srv pend   lost   stat
        // basic single request on channel 3
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  0, 3'd0, 0, 8'h00, 8'd0, 8'h00));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0,  0, 3'd0, 0, 8'h00, 8'd0, 8'h80));
        tbl.push_back(mk(1, 8'h08, 0, 8'h00, 0, 0, 0, 0, 0,  0, 3'd0, 0, 8'h08, 8'd0, 8'h90));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  1, 3'd3, 0, 8'h08, 8'd0, 8'hD0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0,  0, 3'd3, 1, 8'h00, 8'd0, 8'hA0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  0, 3'd3, 1, 8'h00, 8'd0, 8'hA0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0,  0, 3'd3, 0, 8'h00, 8'd0, 8'h80));
        // channels 1 and 6 together: 6 wins, then 1
        tbl.push_back(mk(1, 8'h42, 0, 8'h00, 0, 0, 0, 0, 0,  0, 3'd3, 0, 8'h42, 8'd0, 8'h90));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  1, 3'd6, 0, 8'h42, 8'd0, 8'hD0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0,  0, 3'd6, 1, 8'h02, 8'd0, 8'hB0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0,  0, 3'd6, 0, 8'h02, 8'd0, 8'h90));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  1, 3'd1, 0, 8'h02, 8'd0, 8'hD0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0,  0, 3'd1, 1, 8'h00, 8'd0, 8'hA0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0,  0, 3'd1, 0, 8'h00, 8'd0, 8'h80));
        // mask channel 6; fire 6 and 2; unmask later
        tbl.push_back(mk(1, 8'h00, 1, 8'h40, 0, 0, 0, 0, 0,  0, 3'd1, 0, 8'h00, 8'd0, 8'h80));
        tbl.push_back(mk(1, 8'h44, 0, 8'h00, 0, 0, 0, 0, 0,  0, 3'd1, 0, 8'h44, 8'd0, 8'h90));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  1, 3'd2, 0, 8'h44, 8'd0, 8'hD0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0,  0, 3'd2, 1, 8'h40, 8'd0, 8'hA0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0,  0, 3'd2, 0, 8'h40, 8'd0, 8'h80));
        tbl.push_back(mk(1, 8'h00, 1, 8'h00, 0, 0, 0, 0, 0,  0, 3'd2, 0, 8'h40, 8'd0, 8'h90));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  1, 3'd6, 0, 8'h40, 8'd0, 8'hD0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0,  0, 3'd6, 1, 8'h00, 8'd0, 8'hA0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0,  0, 3'd6, 0, 8'h00, 8'd0, 8'h80));
        // second edge on pending channel 5 is lost; cnt_clr resets the count
        tbl.push_back(mk(1, 8'h20, 0, 8'h00, 0, 0, 0, 0, 0,  0, 3'd6, 0, 8'h20, 8'd0, 8'h90));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  1, 3'd5, 0, 8'h20, 8'd0, 8'hD0));
        tbl.push_back(mk(1, 8'h20, 0, 8'h00, 0, 0, 0, 0, 0,  1, 3'd5, 0, 8'h20, 8'd1, 8'hD0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  1, 3'd5, 0, 8'h20, 8'd1, 8'hD0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1,  1, 3'd5, 0, 8'h20, 8'd0, 8'hD0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0,  0, 3'd5, 1, 8'h00, 8'd0, 8'hA0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0,  0, 3'd5, 0, 8'h00, 8'd0, 8'h80));
        // ack of channel 4 coincides with a new rise on 4: re-pended, not lost
        tbl.push_back(mk(1, 8'h10, 0, 8'h00, 0, 0, 0, 0, 0,  0, 3'd5, 0, 8'h10, 8'd0, 8'h90));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  1, 3'd4, 0, 8'h10, 8'd0, 8'hD0));
        tbl.push_back(mk(1, 8'h10, 0, 8'h00, 0, 0, 1, 0, 0,  0, 3'd4, 1, 8'h10, 8'd0, 8'hB0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  0, 3'd4, 1, 8'h10, 8'd0, 8'hB0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0,  0, 3'd4, 0, 8'h10, 8'd0, 8'h90));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  1, 3'd4, 0, 8'h10, 8'd0, 8'hD0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0,  0, 3'd4, 1, 8'h00, 8'd0, 8'hA0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0,  0, 3'd4, 0, 8'h00, 8'd0, 8'h80));
        // reset while in REQ; line held high across reset release; stray ack/eoi ignored
        tbl.push_back(mk(1, 8'h01, 0, 8'h00, 0, 0, 0, 0, 0,  0, 3'd4, 0, 8'h01, 8'd0, 8'h90));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  1, 3'd0, 0, 8'h01, 8'd0, 8'hD0));
        tbl.push_back(mk(0, 8'h02, 0, 8'h00, 0, 0, 0, 0, 0,  0, 3'd0, 0, 8'h00, 8'd0, 8'h00));
        tbl.push_back(mk(1, 8'h02, 0, 8'h00, 0, 0, 0, 0, 0,  0, 3'd0, 0, 8'h02, 8'd0, 8'h10));
        tbl.push_back(mk(1, 8'h02, 0, 8'h00, 0, 0, 0, 1, 0,  0, 3'd0, 0, 8'h02, 8'd0, 8'h10));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0,  0, 3'd0, 0, 8'h02, 8'd0, 8'h10));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0,  0, 3'd0, 0, 8'h02, 8'd0, 8'h90));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0,  1, 3'd1, 0, 8'h02, 8'd0, 8'hD0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0,  0, 3'd1, 1, 8'h00, 8'd0, 8'hA0));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0,  0, 3'd1, 0, 8'h00, 8'd0, 8'h80));

        idle_inputs();
        rstN = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            rstN = tbl[i].rst_n; irq_in = tbl[i].irq; mask_wr = tbl[i].mwr;
            mask_wdata = tbl[i].mdat; ien_wr = tbl[i].iwr; ien_wdata = tbl[i].idat;
            irq_ack = tbl[i].ack; eoi = tbl[i].eoi; cnt_clr = tbl[i].cclr;
            cyc();
            chk("irq_valid", i, 32'(irq_valid), 32'(tbl[i].vld));
            chk("irq_id", i, 32'(irq_id), 32'(tbl[i].id));
            chk("in_service", i, 32'(in_service), 32'(tbl[i].srv));
            chk("pending", i, 32'(pending), 32'(tbl[i].pend));
            chk("lost_cnt", i, 32'(lost_cnt), 32'(tbl[i].lost));
            chk("status", i, 32'(status), 32'(tbl[i].stat));
        end

        // Saturation: channel 5 pended once, then 300 dropped edges while held in REQ.
        idle_inputs();
        irq_in = 8'h20;
        cyc();
        for (int i = 1; i <= 300; i++) begin
            irq_in = 8'h00;
            cyc();
            irq_in = 8'h20;
            cyc();
            if (i == 100) chk("lost_cnt_100", i, 32'(lost_cnt), 32'd100);
        end
        chk("lost_cnt_sat", 300, 32'(lost_cnt), 32'd255);
        chk("sat_valid", 300, 32'(irq_valid), 32'd1);
        chk("sat_id", 300, 32'(irq_id), 32'd5);
        // Clear wins over a simultaneous drop.
        irq_in = 8'h00;
        cyc();
        irq_in = 8'h20;
        cnt_clr = 1'b1;
        cyc();
        chk("lost_cnt_clr", 0, 32'(lost_cnt), 32'd0);
        // Ack held over several cycles: one transition, rest ignored.
        idle_inputs();
        irq_in = 8'h20;
        irq_ack = 1'b1;
        cyc();
        cyc();
        chk("held_ack_srv", 0, 32'(in_service), 32'd1);
        chk("held_ack_pend", 0, 32'(pending), 32'h00);
        chk("held_ack_valid", 0, 32'(irq_valid), 32'd0);
        irq_ack = 1'b0;
        eoi = 1'b1;
        cyc();
        chk("eoi_srv", 0, 32'(in_service), 32'd0);
        chk("eoi_next_valid", 0, 32'(irq_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
